// File: rtl/bg_band_filler.sv
// Background band filler: per-pixel sky/band/ground palette index generator with
// a 3-stage pipeline that fetches packed band pixels from a synchronous VRAM.
module bg_band_filler #(
   parameter int unsigned PAL_W        = 5,
   parameter int unsigned PIX_W        = 3,
   parameter int unsigned PIX_PER_WORD = 3,
   parameter int unsigned WPL_LOG2     = 8,
   parameter int unsigned ROW_W        = 7,
   parameter logic [9:0]  SKY_END      = 10'd300,
   parameter logic [9:0]  GROUND_START = 10'd428,
   parameter logic [3:0]  SKY_INDEX    = 4'h5,
   parameter logic [3:0]  GROUND_INDEX = 4'h7
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            pix_valid,
   input  logic [9:0]                      x,
   input  logic [9:0]                      y,
   input  logic [WPL_LOG2-1:0]             scroll_words,
   input  logic [PAL_W-1:0]                palette_sel,
   input  logic                            band_en,
   output logic [ROW_W+WPL_LOG2-1:0]       ram_addr,
   input  logic [PIX_W*PIX_PER_WORD-1:0]   ram_rdata,
   output logic [PAL_W+3:0]                index_out,
   output logic                            index_valid
);

   localparam int unsigned SLOT_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

   typedef enum logic [1:0] {REG_SKY, REG_BAND, REG_GROUND} region_t;

   logic [WPL_LOG2-1:0]       r_scroll;
   logic [PAL_W-1:0]          r_pal;
   logic                      r_band_en;
   logic [SLOT_W-1:0]         r_slot;
   logic [WPL_LOG2-1:0]       r_word;

   logic                      r_s1_vld, r_s2_vld;
   region_t                   r_s1_reg, r_s2_reg;
   logic [SLOT_W-1:0]         r_s1_slot, r_s2_slot;
   logic [PAL_W-1:0]          r_s1_pal, r_s2_pal;

   logic [ROW_W+WPL_LOG2-1:0] r_ram_addr;
   logic [PAL_W+3:0]          r_index_out;
   logic                      r_index_valid;

   logic                      w_fs;
   logic [WPL_LOG2-1:0]       w_scroll;
   logic [PAL_W-1:0]          w_pal;
   logic                      w_band_en;
   logic [SLOT_W-1:0]         w_slot;
   logic [WPL_LOG2-1:0]       w_word;
   logic                      w_slot_wrap;
   logic [ROW_W-1:0]          w_row;
   region_t                   w_region;
   logic [PIX_W-1:0]          w_field;
   logic [PAL_W+3:0]          w_index;

   // Frame-start pixel sees the new frame settings in the same cycle they are latched.
   assign w_fs        = pix_valid && (x == '0) && (y == '0);
   assign w_scroll    = w_fs ? scroll_words : r_scroll;
   assign w_pal       = w_fs ? palette_sel  : r_pal;
   assign w_band_en   = w_fs ? band_en      : r_band_en;
   assign w_slot      = (x == '0) ? '0 : r_slot;
   assign w_word      = (x == '0) ? w_scroll : r_word;
   assign w_slot_wrap = (w_slot == SLOT_W'(PIX_PER_WORD - 1));
   assign w_row       = ROW_W'(y - SKY_END);

   // A disabled band is folded into the sky region so no fetch is issued.
   always_comb begin
      w_region = REG_SKY;
      if (y >= GROUND_START)
         w_region = REG_GROUND;
      else if (y >= SKY_END && w_band_en)
         w_region = REG_BAND;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scroll  <= '0;
         r_pal     <= '0;
         r_band_en <= 1'b1;
         r_slot    <= '0;
         r_word    <= '0;
      end else if (pix_valid) begin
         if (w_fs) begin
            r_scroll  <= scroll_words;
            r_pal     <= palette_sel;
            r_band_en <= band_en;
         end
         r_slot <= w_slot_wrap ? '0 : w_slot + SLOT_W'(1);
         r_word <= w_slot_wrap ? w_word + WPL_LOG2'(1) : w_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ram_addr    <= '0;
         r_s1_vld      <= 1'b0;
         r_s1_reg      <= REG_SKY;
         r_s1_slot     <= '0;
         r_s1_pal      <= '0;
         r_s2_vld      <= 1'b0;
         r_s2_reg      <= REG_SKY;
         r_s2_slot     <= '0;
         r_s2_pal      <= '0;
         r_index_out   <= '0;
         r_index_valid <= 1'b0;
      end else begin
         r_s1_vld <= pix_valid;
         if (pix_valid) begin
            r_s1_reg  <= w_region;
            r_s1_slot <= w_slot;
            r_s1_pal  <= w_pal;
            if (w_region == REG_BAND)
               r_ram_addr <= {w_row, w_word};
         end
         r_s2_vld  <= r_s1_vld;
         r_s2_reg  <= r_s1_reg;
         r_s2_slot <= r_s1_slot;
         r_s2_pal  <= r_s1_pal;
         r_index_valid <= r_s2_vld;
         if (r_s2_vld)
            r_index_out <= w_index;
      end
   end

   // Slot 0 is the most significant field of the VRAM word.
   always_comb begin
      w_field = '0;
      for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
         if (r_s2_slot == SLOT_W'(i))
            w_field = ram_rdata[(PIX_PER_WORD-1-i)*PIX_W +: PIX_W];
      end
   end

   always_comb begin
      w_index = {r_s2_pal, SKY_INDEX};
      case (r_s2_reg)
         REG_BAND:   w_index = {r_s2_pal, 4'(w_field)};
         REG_GROUND: w_index = {r_s2_pal, GROUND_INDEX};
         default:    w_index = {r_s2_pal, SKY_INDEX};
      endcase
   end

   assign ram_addr    = r_ram_addr;
   assign index_out   = r_index_out;
   assign index_valid = r_index_valid;

endmodule

// File: tb/tb_bg_band_filler.sv
// Scoreboard bench for bg_band_filler: a reference model predicts each pixel's index
// and fetch address; results are matched against the DUT output strobes.
module tb_bg_band_filler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_valid = 1'b0;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic [7:0]  scroll_words = '0;
   logic [4:0]  palette_sel = '0;
   logic        band_en = 1'b1;
   logic [14:0] ram_addr;
   logic [8:0]  ram_rdata = '0;
   logic [8:0]  index_out;
   logic        index_valid;

   bg_band_filler #(
      .PAL_W(5), .PIX_W(3), .PIX_PER_WORD(3), .WPL_LOG2(8), .ROW_W(7),
      .SKY_END(10'd300), .GROUND_START(10'd428), .SKY_INDEX(4'h5), .GROUND_INDEX(4'h7)
   ) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .x(x), .y(y),
      .scroll_words(scroll_words), .palette_sel(palette_sel), .band_en(band_en),
      .ram_addr(ram_addr), .ram_rdata(ram_rdata),
      .index_out(index_out), .index_valid(index_valid)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [8:0] vram(input logic [14:0] a);
      if (a == 15'd0) return 9'b001_010_011;
      if (a == 15'd1) return 9'b100_101_110;
      return 9'(a * 15'd13 + (a >> 5));
   endfunction

   always @(posedge clk) ram_rdata <= vram(ram_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [8:0] idx;
      int         cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   logic [8:0] last_idx = '0;

   logic [7:0]  m_scroll;
   logic [4:0]  m_pal;
   logic        m_ben;
   int          m_slot;
   logic [7:0]  m_word;
   logic [14:0] m_addr;

   task automatic model_reset();
      m_scroll = '0; m_pal = '0; m_ben = 1'b1; m_slot = 0; m_word = '0; m_addr = '0;
   endtask

   task automatic send(input logic [9:0] px, input logic [9:0] py, input logic [7:0] sc,
                       input logic [4:0] pal, input logic ben);
      int         slot;
      logic [7:0] word;
      logic [9:0] row;
      logic [8:0] w;
      logic [8:0] sh;
      exp_t       e;
      if (px == 0 && py == 0) begin
         m_scroll = sc; m_pal = pal; m_ben = ben;
      end
      slot = (px == 0) ? 0 : m_slot;
      word = (px == 0) ? m_scroll : m_word;
      if (py < 300)
         e.idx = {m_pal, 4'h5};
      else if (py < 428) begin
         if (m_ben) begin
            row    = py - 10'd300;
            m_addr = {row[6:0], word};
            w      = vram(m_addr);
            sh     = w >> (3 * (2 - slot));
            e.idx  = {m_pal, 1'b0, sh[2:0]};
         end else
            e.idx = {m_pal, 4'h5};
      end else
         e.idx = {m_pal, 4'h7};
      if (slot == 2) begin
         m_slot = 0; m_word = word + 8'd1;
      end else begin
         m_slot = slot + 1; m_word = word;
      end
      x = px; y = py; scroll_words = sc; palette_sel = pal; band_en = ben;
      pix_valid = 1'b1;
      e.cyc = cyc + 3;
      q.push_back(e);
      @(posedge clk);
      #1;
      check("ram_addr", 32'(ram_addr), 32'(m_addr));
      pix_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && index_valid) begin
         if (q.size() == 0)
            check("unexpected_valid", 32'd1, 32'd0);
         else begin
            mon_e = q.pop_front();
            check("index", 32'(index_out), 32'(mon_e.idx));
            check("latency", 32'(cyc), 32'(mon_e.cyc));
            last_idx = index_out;
         end
      end
   end

   initial begin
      model_reset();
      #3;
      check("rst_index_out", 32'(index_out), 32'd0);
      check("rst_index_valid", 32'(index_valid), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;

      // palette 3 at frame start, then a sky pixel
      send(10'd0, 10'd0, 8'd0, 5'd3, 1'b1);
      send(10'd1, 10'd10, 8'd0, 5'd3, 1'b1);
      idle(5);

      // band row 0, words 0 and 1
      for (int i = 0; i < 6; i++) send(10'(i), 10'd300, 8'd0, 5'd3, 1'b1);
      idle(2);

      // band/ground boundary on consecutive pixels
      send(10'd0, 10'd427, 8'd0, 5'd3, 1'b1);
      send(10'd1, 10'd428, 8'd0, 5'd3, 1'b1);
      idle(6);
      check("hold_index", 32'(index_out), 32'(last_idx));

      // mid-frame input changes must be ignored
      send(10'd5, 10'd100, 8'd77, 5'd9, 1'b0);
      send(10'd6, 10'd310, 8'd77, 5'd9, 1'b0);
      idle(4);

      // scroll 255 wraps to word 0 on the fourth pixel
      send(10'd0, 10'd0, 8'd255, 5'd2, 1'b1);
      for (int i = 0; i < 4; i++) send(10'(i), 10'd300, 8'd255, 5'd2, 1'b1);
      idle(3);

      // band disabled: sky index, no fetch
      send(10'd0, 10'd0, 8'd4, 5'd1, 1'b0);
      for (int i = 0; i < 3; i++) send(10'(i), 10'd350, 8'd4, 5'd1, 1'b0);
      idle(3);

      send(10'd0, 10'd0, 8'd17, 5'd22, 1'b1);
      begin
         logic [9:0] px = 10'd1;
         logic [9:0] py = 10'd290;
         for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) px = 10'd0;
            if ($urandom_range(0, 3) == 0) py = 10'($urandom_range(250, 450));
            send(px, py, 8'($urandom), 5'($urandom), 1'($urandom));
            px = px + 10'd1;
            if ($urandom_range(0, 3) == 0) idle(1);
         end
      end
      idle(5);

      // reset with two pixels in flight
      send(10'd0, 10'd0, 8'd3, 5'd7, 1'b1);
      send(10'd1, 10'd320, 8'd3, 5'd7, 1'b1);
      #1 rst = 1'b1;
      q.delete();
      #1;
      check("midrst_index_out", 32'(index_out), 32'd0);
      check("midrst_index_valid", 32'(index_valid), 32'd0);
      check("midrst_ram_addr", 32'(ram_addr), 32'd0);
      model_reset();
      #1 rst = 1'b0;
      send(10'd3, 10'd20, 8'd9, 5'd9, 1'b1);
      send(10'd0, 10'd305, 8'd9, 5'd9, 1'b1);
      send(10'd1, 10'd305, 8'd9, 5'd9, 1'b1);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bg_band_filler.md
BG_BAND_FILLER -- requirements
Module: bg_band_filler

Interface
REQ-001 SHALL have parameter PAL_W, default 5, meaning palette-select width.
REQ-002 SHALL have parameter PIX_W, default 3, meaning bits per band pixel; legal range 1..4.
REQ-003 SHALL have parameter PIX_PER_WORD, default 3, meaning pixels packed per VRAM word; VRAM word width = PIX_W*PIX_PER_WORD.
REQ-004 SHALL have parameter WPL_LOG2, default 8, meaning log2 of VRAM words per band row.
REQ-005 SHALL have parameter ROW_W, default 7, meaning band-row address width.
REQ-006 SHALL have parameters SKY_END=300, GROUND_START=428 (10-bit each), meaning region boundaries in y.
REQ-007 SHALL have parameters SKY_INDEX=4'h5, GROUND_INDEX=4'h7, meaning low 4 index bits for the flat regions.
REQ-008 SHALL be clocked by a single clock and reset asynchronously, active-high.
REQ-009 clk  in  1  system clock, rising edge.
REQ-010 rst  in  1  asynchronous active-high reset.
REQ-011 pix_valid  in  1  one-cycle strobe; x,y describe a new pixel this cycle.
REQ-012 x  in  10  pixel column.
REQ-013 y  in  10  pixel row.
REQ-014 scroll_words  in  WPL_LOG2  horizontal scroll in VRAM words.
REQ-015 palette_sel  in  PAL_W  palette for all regions.
REQ-016 band_en  in  1  0 = band region drawn as sky, no fetch.
REQ-017 ram_addr  out  ROW_W+WPL_LOG2  registered VRAM read address.
REQ-018 ram_rdata  in  PIX_W*PIX_PER_WORD  synchronous VRAM data, valid the cycle after ram_addr is presented.
REQ-019 index_out  out  PAL_W+4  registered palette index.
REQ-020 index_valid  out  1  one-cycle strobe, index_out updated.

Function
REQ-021 Region per pixel: y<SKY_END sky; SKY_END<=y<GROUND_START band; y>=GROUND_START ground.
REQ-022 Sky pixel index SHALL be {pal_q,SKY_INDEX}; ground {pal_q,GROUND_INDEX}; band with band_en_q=0 {pal_q,SKY_INDEX}.
REQ-023 scroll_q, pal_q, band_en_q SHALL load from inputs only on pix_valid with x==0 and y==0 (that pixel uses new values); mid-frame input changes ignored.
REQ-024 Cursor for the current pixel: if x==0, slot=0, word=scroll_q (or scroll_words at frame start); else stored slot_q, word_q.
REQ-025 On each pix_valid, slot_q<=slot+1, wrapping PIX_PER_WORD-1->0; on wrap word_q<=word+1 mod 2^WPL_LOG2; cursor updates in every region.
REQ-026 Band row = (y-SKY_END) truncated to ROW_W bits; address = {band_row, word}.
REQ-027 Stage 1 (edge ending pix_valid cycle T): register ram_addr (band pixels only, else hold), region, slot, valid.
REQ-028 Stage 2 (edge ending T+1): forward region/slot/valid; RAM samples ram_addr.
REQ-029 Stage 3 (edge ending T+2): index_out registered; index_valid high during T+3 only; latency exactly 3 cycles.
REQ-030 Band index = {pal_q, zero-extended field}; slot 0 = most significant PIX_W bits of ram_rdata, slot PIX_PER_WORD-1 = least significant.
REQ-031 pix_valid back-to-back each cycle SHALL be sustained; gaps produce no index_valid; index_out holds between strobes.
REQ-032 Region and palette SHALL travel with the pixel through the pipeline; a region change between consecutive pixels yields no mixing.

Reset
REQ-033 On rst: index_out=0, index_valid=0, ram_addr=0, slot_q=0, word_q=0, scroll_q=0, pal_q=0, band_en_q=1, all pipeline valids 0, immediately without clock.
REQ-034 Reset mid-pipeline SHALL discard in-flight pixels; first index_valid after release is 3 cycles after the first accepted pix_valid.

Verification
REQ-035 rst pulse between edges -> index_out=0, index_valid=0 before next clk edge.
REQ-036 Frame start x=0,y=0, palette_sel=3, then pixel y=10 -> index_out=0x35 three cycles later.
REQ-037 y=300, x=0..5 continuous, scroll_words=0, ram_rdata word0=9'b001_010_011, word1=9'b100_101_110 -> ram_addr 0,0,0,1,1,1; indices low bits 1,2,3,4,5,6.
REQ-038 scroll_words=255 latched at frame start, band row 0, x=0..3 -> ram_addr 255,255,255,0 (wrap).
REQ-039 y=427 then y=428 consecutive pixels -> band-fetched index followed by {pal_q,7}, each 3 cycles after its strobe.
REQ-040 band_en=0 at frame start, y=350 -> index low bits 5, ram_addr unchanged.
